instr_fetch: RTL and testbench

Instruction fetch stage for the single-issue RV32I core. It owns the program counter, requests 32-bit words from instruction memory over a req/rvalid protocol, and buffers each fetched word. It presents each word to the decode stage (control unit plus register-file read) as `instrCode` under a valid/ready handshake. Branch/jump redirects from execute overwrite the PC and squash any fetched or in-flight instruction.

---
 rtl/instr_fetch.sv | 88 ++++++++
 tb/tb_instr_fetch.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, fetches words over req/rvalid and
// buffers each word for decode behind a valid/ready handshake.
//
// state | meaning
// IDLE  | just out of reset, no request issued yet
// REQ   | imem_req high, waiting for the response at pc
// HOLD  | instruction buffered, instr_valid high until accepted or redirected
// FLUSH | response still owed for a squashed request, discard it when it lands
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instrCode,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;
    localparam logic [1:0] FLUSH = 2'd3;

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] redirect_aligned;

    assign redirect_aligned = redirect_pc & ~32'd3;

    assign imem_addr   = pc;
    assign imem_req    = (state == REQ);
    assign instr_valid = (state == HOLD);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            instrCode <= 32'h0;
            instr_pc  <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    state <= REQ;
                    if (redirect_valid)
                        pc <= redirect_aligned;
                end
                REQ: begin
                    if (imem_rvalid && !redirect_valid) begin
                        instrCode <= imem_rdata;
                        instr_pc  <= pc;
                        pc        <= pc + 32'd4;
                        state     <= HOLD;
                    end else if (imem_rvalid && redirect_valid) begin
                        pc    <= redirect_aligned;
                        state <= REQ;
                    end else if (redirect_valid) begin
                        // the squashed request's response is still in flight
                        pc    <= redirect_aligned;
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (redirect_valid)
                        pc <= redirect_aligned;
                    if (imem_rvalid)
                        state <= REQ;
                end
                HOLD: begin
                    if (redirect_valid) begin
                        pc    <= redirect_aligned;
                        state <= REQ;
                    end else if (instr_ready) begin
                        state <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a latency-programmable memory model
// and a second instance fetching across the top of the address space.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req, imem_rvalid, instr_valid, instr_ready, redirect_valid;
    logic [31:0] imem_addr, imem_rdata, instrCode, instr_pc, redirect_pc;

    logic        imem_req2, instr_valid2;
    logic [31:0] imem_addr2, instrCode2, instr_pc2, imem_rdata2;

    int unsigned passed = 0;
    int unsigned total  = 0;
    int unsigned acc8   = 0;
    int          lat;
    int          cnt;
    logic        pend;
    logic [31:0] addr_l;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h0000_0000: rom = 32'h0020_81B3;
            32'h0000_0004: rom = 32'h4020_81B3;
            default:       rom = a ^ 32'h1357_9BDF;
        endcase
    endfunction

    // memory: response lat cycles after the request starts, owed even if req drops
    assign imem_rvalid = (pend || imem_req) && (cnt == lat);
    assign imem_rdata  = rom(pend ? addr_l : imem_addr);

    always @(posedge clk) begin
        if (reset) begin
            pend <= 1'b0;
            cnt  <= 0;
        end else if (imem_rvalid) begin
            pend <= 1'b0;
            cnt  <= 0;
        end else if (pend || imem_req) begin
            if (!pend)
                addr_l <= imem_addr;
            pend <= 1'b1;
            cnt  <= cnt + 1;
        end
    end

    always @(posedge clk)
        if (!reset && instr_valid && instr_ready && instr_pc == 32'h8)
            acc8 <= acc8 + 1;

    assign imem_rdata2 = imem_addr2 ^ 32'h0F0F_0000;

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instrCode(instrCode), .instr_pc(instr_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .reset(reset),
        .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_rvalid(1'b1), .imem_rdata(imem_rdata2),
        .instr_valid(instr_valid2), .instr_ready(1'b1),
        .instrCode(instrCode2), .instr_pc(instr_pc2),
        .redirect_valid(1'b0), .redirect_pc(32'h0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; instr_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; lat = 0;
        step(); step();
        check("rst_req", imem_req, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_code", instrCode, 0);
        check("rst_pc", instr_pc, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_addr2", imem_addr2, 32'hFFFF_FFFC);

        // zero-latency ROM, decode always ready
        reset = 1'b0;
        step();
        check("t1_req", imem_req, 1);
        check("t1_addr", imem_addr, 0);
        check("t1_valid0", instr_valid, 0);
        step();
        check("t1_valid1", instr_valid, 1);
        check("t1_pc0", instr_pc, 0);
        check("t1_code0", instrCode, 32'h0020_81B3);
        check("t5_pc_a", instr_pc2, 32'hFFFF_FFFC);
        step();
        check("t1_valid_gap", instr_valid, 0);
        check("t1_addr4", imem_addr, 4);
        check("t5_addr_wrap", imem_addr2, 0);
        step();
        check("t1_valid2", instr_valid, 1);
        check("t1_pc4", instr_pc, 4);
        check("t1_code4", instrCode, 32'h4020_81B3);
        check("t5_pc_b", instr_pc2, 0);

        // latency 3, then a 5-cycle stall in HOLD
        lat = 3;
        step();
        check("t2_req", imem_req, 1);
        check("t2_addr", imem_addr, 8);
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t2_wait_req", imem_req, 1);
            check("t2_wait_valid", instr_valid, 0);
        end
        step();
        check("t2_valid", instr_valid, 1);
        check("t2_pc", instr_pc, 8);
        check("t2_code", instrCode, rom(32'h8));
        for (int i = 0; i < 5; i++) begin
            step();
            check("t2_stall_valid", instr_valid, 1);
            check("t2_stall_code", instrCode, rom(32'h8));
            check("t2_stall_pc", instr_pc, 8);
            check("t2_stall_req", imem_req, 0);
        end

        // redirect from HOLD, low address bits dropped
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; lat = 0;
        step();
        check("t3_addr", imem_addr, 32'h100);
        check("t3_valid", instr_valid, 0);
        redirect_valid = 1'b0; instr_ready = 1'b1;
        step();
        check("t3_pc", instr_pc, 32'h100);
        check("t3_code", instrCode, rom(32'h100));
        check("t3_acc8", acc8, 0);

        // latency 4, redirect one cycle after the request: FLUSH
        lat = 4;
        step();
        check("t4_addr", imem_addr, 32'h104);
        step();
        check("t4_req_hold", imem_req, 1);
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        step();
        check("t4_flush_req", imem_req, 0);
        check("t4_flush_addr", imem_addr, 32'h200);
        redirect_valid = 1'b0;
        step();
        check("t4_flush_req2", imem_req, 0);
        step();
        check("t4_flush_req3", imem_req, 0);
        step();
        check("t4_new_req", imem_req, 1);
        check("t4_new_addr", imem_addr, 32'h200);
        lat = 0;
        step();
        check("t4_pc", instr_pc, 32'h200);
        check("t4_code", instrCode, rom(32'h200));

        // reset in HOLD, then in REQ
        reset = 1'b1;
        step();
        check("t6_hold_valid", instr_valid, 0);
        check("t6_hold_req", imem_req, 0);
        check("t6_hold_code", instrCode, 0);
        reset = 1'b0;
        step();
        check("t6_restart_addr", imem_addr, 0);
        check("t6_restart_req", imem_req, 1);
        step();
        check("t6_code0", instrCode, 32'h0020_81B3);
        step();
        check("t6_req_state", imem_req, 1);
        check("t6_code_kept", instrCode, 32'h0020_81B3);
        reset = 1'b1;
        step();
        check("t6_req_valid", instr_valid, 0);
        check("t6_req_req", imem_req, 0);
        check("t6_req_code", instrCode, 0);
        reset = 1'b0;
        step();
        check("t6_restart2_addr", imem_addr, 0);
        check("t6_restart2_req", imem_req, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
